// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32 sequencer: FETCH/DECODE/EXEC/(MULW)/WB with ALU decode,
// multiplier start/done handshake with timeout, sticky flags and a retire counter.
module multicycle_sequencer #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MUL_TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [31:0]      instr_i,
  input  logic             mul_done_i,
  output logic             pc_we_o,
  output logic             ir_we_o,
  output logic             regfile_we_o,
  output logic             alu_src_o,
  output logic [2:0]       alu_ctrl_o,
  output logic             mul_start_o,
  output logic             busy_o,
  output logic             illegal_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] retired_o
);

  localparam int unsigned TO_W = (MUL_TIMEOUT > 1) ? $clog2(MUL_TIMEOUT) : 1;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRA = 3'b110;
  localparam logic [2:0] ALU_MUL = 3'b111;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MULW,
    S_WB
  } state_t;

  state_t state_q, state_d;

  logic [6:0]      funct7_q;
  logic [2:0]      funct3_q;
  logic [6:0]      opcode_q;
  logic            illegal_q, illegal_d;
  logic            abort_q, abort_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [2:0]      ctrl_d;
  logic            src_d;

  logic            dec_legal;
  logic [2:0]      dec_ctrl;
  logic            dec_src;

  // Register and operand fields are not needed by the sequencer.
  logic unused_instr;
  assign unused_instr = ^{instr_i[24:15], instr_i[11:7]};

  // Capture the decode-relevant instruction fields alongside the IR write.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      funct7_q <= 7'd0;
      funct3_q <= 3'd0;
      opcode_q <= 7'd0;
    end else if (state_q == S_FETCH) begin
      funct7_q <= instr_i[31:25];
      funct3_q <= instr_i[14:12];
      opcode_q <= instr_i[6:0];
    end
  end

  // Decode latched opcode/funct fields into ALU control and operand select.
  always_comb begin
    dec_legal = 1'b0;
    dec_ctrl  = ALU_ADD;
    dec_src   = 1'b0;
    case (opcode_q)
      OP_R: begin
        dec_legal = 1'b1;
        case ({funct7_q, funct3_q})
          10'b0000000_000: dec_ctrl = ALU_ADD;
          10'b0000000_111: dec_ctrl = ALU_AND;
          10'b0000000_110: dec_ctrl = ALU_OR;
          10'b0000000_100: dec_ctrl = ALU_XOR;
          10'b0000000_001: dec_ctrl = ALU_SLL;
          10'b0100000_000: dec_ctrl = ALU_SUB;
          10'b0100000_101: dec_ctrl = ALU_SRA;
          10'b0000001_000: dec_ctrl = ALU_MUL;
          default:         dec_legal = 1'b0;
        endcase
      end
      OP_I: begin
        dec_legal = 1'b1;
        dec_src   = 1'b1;
        case (funct3_q)
          3'b000:  dec_ctrl = ALU_ADD;
          3'b100:  dec_ctrl = ALU_XOR;
          3'b110:  dec_ctrl = ALU_OR;
          3'b111:  dec_ctrl = ALU_AND;
          3'b001: begin
            dec_ctrl  = ALU_SLL;
            dec_legal = (funct7_q == 7'b0000000);
          end
          3'b101: begin
            dec_ctrl  = ALU_SRA;
            dec_legal = (funct7_q == 7'b0100000);
          end
          default: dec_legal = 1'b0;
        endcase
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Next-state, per-instruction flags, timeout count and held ALU control.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    abort_d   = abort_q;
    cnt_d     = cnt_q;
    ctrl_d    = alu_ctrl_o;
    src_d     = alu_src_o;
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        illegal_d = 1'b0;
        abort_d   = 1'b0;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        if (dec_legal) begin
          ctrl_d  = dec_ctrl;
          src_d   = dec_src;
          state_d = S_EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_WB;
        end
      end
      S_EXEC: begin
        if (alu_ctrl_o == ALU_MUL) begin
          cnt_d   = '0;
          state_d = S_MULW;
        end else begin
          state_d = S_WB;
        end
      end
      S_MULW: begin
        if (mul_done_i) begin
          state_d = S_WB;
        end else if (cnt_q == TO_W'(MUL_TIMEOUT - 1)) begin
          abort_d = 1'b1;
          state_d = S_WB;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      S_WB: begin
        ctrl_d  = 3'b000;
        src_d   = 1'b0;
        state_d = start_i ? S_FETCH : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and per-instruction bookkeeping registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
      abort_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      abort_q   <= abort_d;
      cnt_q     <= cnt_d;
    end
  end

  // Registered outputs, derived from the state being entered.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ir_we_o      <= 1'b0;
      pc_we_o      <= 1'b0;
      regfile_we_o <= 1'b0;
      alu_ctrl_o   <= 3'b000;
      alu_src_o    <= 1'b0;
      mul_start_o  <= 1'b0;
      busy_o       <= 1'b0;
      illegal_o    <= 1'b0;
      timeout_o    <= 1'b0;
      retired_o    <= '0;
    end else begin
      ir_we_o      <= (state_d == S_FETCH);
      pc_we_o      <= (state_d == S_WB);
      regfile_we_o <= (state_d == S_WB) && !illegal_d && !abort_d;
      alu_ctrl_o   <= ctrl_d;
      alu_src_o    <= src_d;
      mul_start_o  <= (state_q == S_DECODE) && (state_d == S_EXEC) && (dec_ctrl == ALU_MUL);
      busy_o       <= (state_d != S_IDLE);
      if (illegal_d) illegal_o <= 1'b1;
      if (abort_d) timeout_o <= 1'b1;
      if ((state_q == S_WB) && !illegal_q && !abort_q) retired_o <= retired_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed self-checking bench for multicycle_sequencer (CNT_W=2, MUL_TIMEOUT=4).
module tb_multicycle_sequencer;

  localparam int unsigned CNT_W  = 2;
  localparam int unsigned MUL_TO = 4;

  localparam int K_OK  = 0;
  localparam int K_ILL = 1;
  localparam int K_MUL = 2;

  logic             clk;
  logic             rst_i;
  logic             start_i;
  logic [31:0]      instr_i;
  logic             mul_done_i;
  logic             pc_we_o;
  logic             ir_we_o;
  logic             regfile_we_o;
  logic             alu_src_o;
  logic [2:0]       alu_ctrl_o;
  logic             mul_start_o;
  logic             busy_o;
  logic             illegal_o;
  logic             timeout_o;
  logic [CNT_W-1:0] retired_o;

  int n_tests = 0;
  int n_fail  = 0;

  int exp_ret = 0;
  bit exp_ill = 1'b0;
  bit exp_to  = 1'b0;

  multicycle_sequencer #(.CNT_W(CNT_W), .MUL_TIMEOUT(MUL_TO)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .instr_i      (instr_i),
    .mul_done_i   (mul_done_i),
    .pc_we_o      (pc_we_o),
    .ir_we_o      (ir_we_o),
    .regfile_we_o (regfile_we_o),
    .alu_src_o    (alu_src_o),
    .alu_ctrl_o   (alu_ctrl_o),
    .mul_start_o  (mul_start_o),
    .busy_o       (busy_o),
    .illegal_o    (illegal_o),
    .timeout_o    (timeout_o),
    .retired_o    (retired_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".pc_we"},   32'(pc_we_o),      32'd0);
    check({tag, ".ir_we"},   32'(ir_we_o),      32'd0);
    check({tag, ".rf_we"},   32'(regfile_we_o), 32'd0);
    check({tag, ".src"},     32'(alu_src_o),    32'd0);
    check({tag, ".ctrl"},    32'(alu_ctrl_o),   32'd0);
    check({tag, ".mstart"},  32'(mul_start_o),  32'd0);
    check({tag, ".busy"},    32'(busy_o),       32'd0);
    check({tag, ".illegal"}, 32'(illegal_o),    32'd0);
    check({tag, ".timeout"}, 32'(timeout_o),    32'd0);
    check({tag, ".retired"}, 32'(retired_o),    32'd0);
  endtask

  // Runs one instruction from the cycle before FETCH up to the WB sample point.
  // done_k: MULW cycle index carrying mul_done_i, or -1 for none.
  task automatic run_instr(input string tag, input logic [31:0] instr, input logic [2:0] ctrl,
                           input logic src, input int kind, input int done_k, input bit keep);
    int  cyc;
    int  exp_wb;
    bit  commit;
    instr_i = instr;
    start_i = 1'b1;
    cyc = 0;
    step();
    check({tag, ".fetch_ir_we"}, 32'(ir_we_o),   32'd1);
    check({tag, ".fetch_busy"},  32'(busy_o),    32'd1);
    check({tag, ".fetch_pc_we"}, 32'(pc_we_o),   32'd0);
    check({tag, ".fetch_ret"},   32'(retired_o), 32'(exp_ret));
    step(); cyc++;
    check({tag, ".dec_ir_we"}, 32'(ir_we_o),    32'd0);
    check({tag, ".dec_ctrl"},  32'(alu_ctrl_o), 32'd0);
    commit = 1'b1;
    if (kind == K_ILL) begin
      commit = 1'b0;
      exp_wb = 2;
    end else begin
      step(); cyc++;
      check({tag, ".ex_ctrl"},   32'(alu_ctrl_o),  32'(ctrl));
      check({tag, ".ex_src"},    32'(alu_src_o),   32'(src));
      check({tag, ".ex_mstart"}, 32'(mul_start_o), 32'(kind == K_MUL));
      exp_wb = 3;
      if (kind == K_MUL) begin
        mul_done_i = 1'b1;
        for (int i = 0; i < int'(MUL_TO); i++) begin
          step(); cyc++;
          check({tag, ".mw_ctrl"},   32'(alu_ctrl_o),  32'd7);
          check({tag, ".mw_mstart"}, 32'(mul_start_o), 32'd0);
          check({tag, ".mw_pc_we"},  32'(pc_we_o),     32'd0);
          mul_done_i = (i == done_k);
          if (i == done_k) break;
        end
        if (done_k < 0) begin
          commit = 1'b0;
          exp_to = 1'b1;
          exp_wb = 3 + int'(MUL_TO);
        end else begin
          exp_wb = 4 + done_k;
        end
      end
    end
    step(); cyc++;
    mul_done_i = 1'b0;
    if (kind == K_ILL) exp_ill = 1'b1;
    check({tag, ".wb_cycle"},   cyc,                 32'(exp_wb));
    check({tag, ".wb_pc_we"},   32'(pc_we_o),        32'd1);
    check({tag, ".wb_rf_we"},   32'(regfile_we_o),   32'(commit));
    if (kind != K_ILL) begin
      check({tag, ".wb_ctrl"},  32'(alu_ctrl_o),     32'(ctrl));
      check({tag, ".wb_src"},   32'(alu_src_o),      32'(src));
    end
    check({tag, ".wb_illegal"}, 32'(illegal_o),      32'(exp_ill));
    check({tag, ".wb_timeout"}, 32'(timeout_o),      32'(exp_to));
    if (commit) exp_ret = (exp_ret + 1) % (1 << CNT_W);
    start_i = keep;
  endtask

  task automatic go_idle(input string tag);
    step();
    check({tag, ".idle_busy"}, 32'(busy_o),    32'd0);
    check({tag, ".idle_ret"},  32'(retired_o), 32'(exp_ret));
    check({tag, ".idle_pc"},   32'(pc_we_o),   32'd0);
  endtask

  initial begin
    rst_i      = 1'b0;
    start_i    = 1'b0;
    instr_i    = 32'd0;
    mul_done_i = 1'b0;
    #1;
    check_all_zero("por");
    step();
    step();
    rst_i = 1'b1;
    step();
    check("idle_wait_busy", 32'(busy_o), 32'd0);

    run_instr("add", 32'h002081B3, 3'b000, 1'b0, K_OK, -1, 1'b0);
    go_idle("add");

    run_instr("srai", 32'h4022D293, 3'b110, 1'b1, K_OK, -1, 1'b1);
    run_instr("srai_bad", 32'h0022D293, 3'b000, 1'b0, K_ILL, -1, 1'b0);
    go_idle("srai_bad");

    // done arrives on the last permitted MULW cycle and must win
    run_instr("mul", 32'h02208233, 3'b111, 1'b0, K_MUL, 3, 1'b0);
    go_idle("mul");

    run_instr("mul_to", 32'h02208233, 3'b111, 1'b0, K_MUL, -1, 1'b0);
    go_idle("mul_to");

    // asynchronous reset while a MUL sits in EXEC
    instr_i = 32'h02208233;
    start_i = 1'b1;
    step();
    step();
    step();
    check("rst_pre_mstart", 32'(mul_start_o), 32'd1);
    #2;
    rst_i = 1'b0;
    #1;
    check_all_zero("rst_mid");
    start_i = 1'b0;
    step();
    check("rst_hold_mstart", 32'(mul_start_o), 32'd0);
    check("rst_hold_busy",   32'(busy_o),      32'd0);
    rst_i   = 1'b1;
    exp_ret = 0;
    exp_ill = 1'b0;
    exp_to  = 1'b0;

    run_instr("b2b0", 32'h002081B3, 3'b000, 1'b0, K_OK, -1, 1'b1);
    run_instr("b2b1", 32'h402081B3, 3'b001, 1'b0, K_OK, -1, 1'b1);
    run_instr("b2b2", 32'h0020F1B3, 3'b010, 1'b0, K_OK, -1, 1'b1);
    run_instr("b2b3", 32'h0020E1B3, 3'b011, 1'b0, K_OK, -1, 1'b1);
    run_instr("b2b4", 32'h0020C1B3, 3'b100, 1'b0, K_OK, -1, 1'b1);
    run_instr("b2b5", 32'h002091B3, 3'b101, 1'b0, K_OK, -1, 1'b1);
    run_instr("b2b6", 32'h00500093, 3'b000, 1'b1, K_OK, -1, 1'b0);
    go_idle("b2b");
    check("b2b_ret_wrapped", 32'(retired_o), 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
